fp32_div: RTL and testbench

Sequential IEEE-754 single-precision divider. It computes `a / b` one quotient bit per cycle using restoring division and rounds the result to nearest-even. It is the inverse companion of `fp32_mul` and follows the same number handling: flush-to-zero, canonical NaN, and saturation to infinity. Operands arrive and results leave through independent valid/ready handshakes, so the block sits behind an arithmetic dispatcher that serialises requests.

---
 rtl/fp32_pkg.sv | 46 ++++
 rtl/fp32_round_rne.sv | 41 ++++
 rtl/fp32_div.sv | 174 +++++++++++++++++
 tb/tb_fp32_div.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 constants, flag bit positions and operand classification
// used by the sequential fp32 arithmetic units.
package fp32_pkg;

    localparam int unsigned EXP_BIAS  = 127;
    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP32_INF  = 32'h7F800000;

    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_DIV_ZERO  = 2;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_UNDERFLOW = 0;

    localparam int unsigned DIV_ITERS = 26;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        fp_class_t   cls;
    } fp_unpacked_t;

    // Denormals (exp == 0) classify as zero: the units flush to zero.
    function automatic fp_unpacked_t fp32_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign = x[31];
        u.exp  = x[30:23];
        u.mant = {1'b1, x[22:0]};
        if (x[30:23] == 8'h00) begin
            u.cls = FP_ZERO;
        end else if (x[30:23] == 8'hFF) begin
            u.cls = (x[22:0] != 23'd0) ? FP_NAN : FP_INF;
        end else begin
            u.cls = FP_NORMAL;
        end
        return u;
    endfunction

endpackage

// File: rtl/fp32_round_rne.sv
// Round-to-nearest-even and range check of a normalised significand;
// saturates to infinity and flushes results below the normal range to zero.
module fp32_round_rne
    import fp32_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp,
    input  logic [23:0]       mant,
    input  logic              guard,
    input  logic              round,
    input  logic              sticky,
    output logic [31:0]       result,
    output logic              overflow,
    output logic              underflow
);

    logic              inc;
    logic [24:0]       sum;
    logic [23:0]       mant_adj;
    logic signed [9:0] exp_adj;

    always_comb begin
        inc      = guard & (round | sticky | mant[0]);
        sum      = {1'b0, mant} + {24'd0, inc};
        mant_adj = sum[24] ? 24'h800000 : sum[23:0];
        exp_adj  = sum[24] ? exp + 10'sd1 : exp;

        overflow  = 1'b0;
        underflow = 1'b0;
        result    = {sign, exp_adj[7:0], mant_adj[22:0]};
        // A significand without its hidden bit carries no value and is treated as zero.
        if (exp_adj >= 10'sd255) begin
            result   = {sign, FP32_INF[30:0]};
            overflow = 1'b1;
        end else if (exp_adj <= 10'sd0 || !mant_adj[23]) begin
            result    = {sign, 31'd0};
            underflow = 1'b1;
        end
    end

endmodule

// File: rtl/fp32_div.sv
// Sequential fp32 divider: one restoring-division quotient bit per cycle,
// special operands resolved at acceptance, RNE rounding in a final cycle.
module fp32_div
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ROUND,
        DONE
    } div_state_t;

    div_state_t        state, state_next;
    logic [4:0]        cnt;
    logic [25:0]       rem;
    logic [25:0]       rem_next;
    logic [25:0]       rem_sel;
    logic [23:0]       mb_r;
    logic [25:0]       quo;
    logic signed [9:0] exp_r;
    logic              sign_r;
    logic              q_bit;

    fp_unpacked_t      ua, ub;
    logic              sgn;
    logic              spec_hit;
    logic [31:0]       spec_result;
    logic [3:0]        spec_flags;
    logic              pre_shift;
    logic [24:0]       ma_norm;
    logic [9:0]        exp_init;

    logic [31:0]       rnd_result;
    logic              rnd_ovf, rnd_unf;

    assign ua  = fp32_unpack(a);
    assign ub  = fp32_unpack(b);
    assign sgn = ua.sign ^ ub.sign;

    always_comb begin
        spec_hit    = 1'b1;
        spec_result = '0;
        spec_flags  = '0;
        if (ua.cls == FP_NAN || ub.cls == FP_NAN) begin
            spec_result = FP32_QNAN;
        end else if ((ua.cls == FP_ZERO && ub.cls == FP_ZERO) ||
                     (ua.cls == FP_INF  && ub.cls == FP_INF)) begin
            spec_result               = FP32_QNAN;
            spec_flags[FLAG_INVALID]  = 1'b1;
        end else if (ua.cls == FP_NORMAL && ub.cls == FP_ZERO) begin
            spec_result               = {sgn, FP32_INF[30:0]};
            spec_flags[FLAG_DIV_ZERO] = 1'b1;
        end else if (ua.cls == FP_INF) begin
            spec_result = {sgn, FP32_INF[30:0]};
        end else if (ua.cls == FP_ZERO || ub.cls == FP_INF) begin
            spec_result = {sgn, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Doubling the dividend when ma < mb keeps the quotient in [1,2).
    always_comb begin
        pre_shift = (ua.mant < ub.mant);
        ma_norm   = pre_shift ? {ua.mant, 1'b0} : {1'b0, ua.mant};
        exp_init  = {2'b00, ua.exp} - {2'b00, ub.exp} + 10'(EXP_BIAS) - {9'd0, pre_shift};
    end

    always_comb begin
        q_bit    = (rem >= {2'b00, mb_r});
        rem_sel  = q_bit ? rem - {2'b00, mb_r} : rem;
        rem_next = rem_sel << 1;
    end

    fp32_round_rne u_round (
        .sign      (sign_r),
        .exp       (exp_r),
        .mant      (quo[25:2]),
        .guard     (quo[1]),
        .round     (quo[0]),
        .sticky    (|rem),
        .result    (rnd_result),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = spec_hit ? DONE : DIV;
                end
            end
            DIV: begin
                if (cnt == 5'(DIV_ITERS - 1)) begin
                    state_next = ROUND;
                end
            end
            ROUND: state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            rem    <= '0;
            mb_r   <= '0;
            quo    <= '0;
            exp_r  <= '0;
            sign_r <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem    <= {1'b0, ma_norm};
                        mb_r   <= ub.mant;
                        quo    <= '0;
                        exp_r  <= exp_init;
                        sign_r <= sgn;
                        cnt    <= '0;
                        if (spec_hit) begin
                            result <= spec_result;
                            flags  <= spec_flags;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= {quo[24:0], q_bit};
                    cnt <= cnt + 5'd1;
                end
                ROUND: begin
                    result <= rnd_result;
                    flags  <= {1'b0, 1'b0, rnd_ovf, rnd_unf};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_div.sv
// Directed-vector bench for fp32_div: an integer-arithmetic reference model
// predicts result, flags and latency; a per-cycle monitor checks the DUT.
module tb_fp32_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    fp32_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer quotient of the significands, then RNE and range.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output int lat);
        int              ex, ey, e;
        bit              xn, yn, xi, yi, xz, yz, s, sticky, g, rb;
        longint unsigned ma, mb, q, rm, mant;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        s  = x[31] ^ y[31];
        f   = 4'h0;
        lat = 1;
        if (xn || yn) begin
            r = 32'h7FC00000;
        end else if ((xz && yz) || (xi && yi)) begin
            r = 32'h7FC00000;
            f = 4'h8;
        end else if (yz && !xi) begin
            r = {s, 31'h7F800000};
            f = 4'h4;
        end else if (xi) begin
            r = {s, 31'h7F800000};
        end else if (xz || yi) begin
            r = {s, 31'h0};
        end else begin
            lat    = 28;
            ma     = {40'd0, 1'b1, x[22:0]};
            mb     = {40'd0, 1'b1, y[22:0]};
            q      = (ma << 26) / mb;
            rm     = (ma << 26) % mb;
            e      = ex - ey + 127;
            sticky = (rm != 0);
            if (q >= (64'd1 << 26)) begin
                sticky = sticky | q[0];
                q      = q >> 1;
            end else begin
                e = e - 1;
            end
            mant = q >> 2;
            g    = q[1];
            rb   = q[0];
            if (g && (rb || sticky || mant[0])) mant = mant + 1;
            if (mant == (64'd1 << 24)) begin
                mant = 64'd1 << 23;
                e    = e + 1;
            end
            if (e >= 255) begin
                r = {s, 31'h7F800000};
                f = 4'h2;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                f = 4'h1;
            end else begin
                r = {s, e[7:0], mant[22:0]};
            end
        end
    endfunction

    // Per-cycle monitor; decisions made here apply at the following rising edge.
    bit          busy    = 1'b0;
    bit          was_rst = 1'b0;
    int          cyc     = 0;
    int          valid_cyc = 0;
    logic [31:0] exp_r;
    logic [3:0]  exp_f;
    int          exp_lat;

    always @(negedge clk) begin
        if (rst) begin
            busy    = 1'b0;
            was_rst = 1'b1;
        end else begin
            if (was_rst) begin
                chk("reset_result", result, 0);
                chk("reset_flags", flags, 0);
            end
            was_rst = 1'b0;
            chk("in_ready", in_ready, !busy);
            chk("out_valid", out_valid, busy && (cyc >= valid_cyc));
            if (out_valid) begin
                chk("result", result, exp_r);
                chk("flags", flags, exp_f);
            end
            if (out_valid && out_ready) begin
                busy = 1'b0;
            end else if (in_valid && in_ready) begin
                model(a, b, exp_r, exp_f, exp_lat);
                busy      = 1'b1;
                valid_cyc = cyc + exp_lat;
            end
        end
        cyc++;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    task automatic pin(input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] hr, input logic [3:0] hf, input int hl);
        logic [31:0] mr;
        logic [3:0]  mf;
        int          ml;
        model(va, vb, mr, mf, ml);
        chk("model_result", mr, hr);
        chk("model_flags", mf, hf);
        chk("model_latency", ml, hl);
    endtask

    task automatic issue(input logic [31:0] va, input logic [31:0] vb);
        for (int n = 0; n < 100 && !in_ready; n++) begin
            @(posedge clk); #1;
        end
        chk("accept_timeout", in_ready, 1);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60 && !in_ready; n++) begin
            @(posedge clk); #1;
        end
        chk("idle_timeout", in_ready, 1);
    endtask

    initial begin
        vecs = '{
            '{32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 28},
            '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'h0, 28},
            '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 4'h0, 28},
            '{32'h41200000, 32'h40A00000, 32'h40000000, 4'h0, 28},
            '{32'hC0000000, 32'h3F800000, 32'hC0000000, 4'h0, 28},
            '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'h0, 28},
            '{32'h40A00000, 32'h00000000, 32'h7F800000, 4'h4, 1},
            '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'h8, 1},
            '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h0, 1},
            '{32'h00000000, 32'h7FC00000, 32'h7FC00000, 4'h0, 1},
            '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'h8, 1},
            '{32'h7F800000, 32'h00000000, 32'h7F800000, 4'h0, 1},
            '{32'h7F800000, 32'hBF800000, 32'hFF800000, 4'h0, 1},
            '{32'h3F800000, 32'hFF800000, 32'h80000000, 4'h0, 1},
            '{32'h80400000, 32'h3F800000, 32'h80000000, 4'h0, 1},
            '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'h2, 28},
            '{32'h7F7FFFFF, 32'h3F7FFFFF, 32'h7F800000, 4'h2, 28},
            '{32'h00800000, 32'h4F000000, 32'h00000000, 4'h1, 28},
            '{32'h80800000, 32'h40000000, 32'h80000000, 4'h1, 28},
            '{32'h00800000, 32'h3F800000, 32'h00800000, 4'h0, 28}
        };

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            pin(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f, vecs[i].lat);
            issue(vecs[i].a, vecs[i].b);
            wait_idle();
        end

        // Backpressure: result held, busy-time requests ignored, no same-cycle turnaround.
        out_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000);
        for (int n = 0; n < 40 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid_timeout", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            a        = 32'h3F800000;
            b        = k[0] ? 32'h00000000 : 32'h40400000;
            in_valid = k[0];
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 0);
        end
        a         = 32'h41200000;
        b         = 32'h40A00000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_after_handshake", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_accepted", in_ready, 0);
        wait_idle();

        // Reset during the tenth DIV cycle aborts the operation.
        issue(32'h40C00000, 32'h40000000);
        for (int k = 0; k < 9; k++) begin
            a        = 32'h00000000;
            b        = 32'h00000000;
            in_valid = ~in_valid;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        issue(32'h40C00000, 32'h40000000);
        wait_idle();

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
